pipelined_controller: RTL and testbench

//  Parametrised successor to the combinational opcode decoder: decodes the ID-stage opcode and

---
 rtl/pipelined_controller.sv | 244 ++++++++++++++++++++++++
 tb/tb_pipelined_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_controller.sv
// pipelined_controller
//   Decodes the ID-stage opcode and registers the control bundle into the ID/EX
//   boundary, with flush (bubble) taking priority over stall (hold) over load.
//   A RUN/DRAIN/HALTED state machine stops fetch when HLT_OPCODE is accepted,
//   waits DRAIN_CYCLES edges for EX/MEM/WB to empty, then reports halted until
//   resume is seen.
//   Optional feature macro: CTRL_JUMP_EN (JAL/JALR decode and the Jump output).
//   With it undefined, Jump is tied low and JAL/JALR decode as illegal.
module pipelined_controller #(
  parameter int                    OPCODE_W     = 7,
  parameter int                    DRAIN_CYCLES = 3,
  parameter logic [OPCODE_W-1:0]   HLT_OPCODE   = OPCODE_W'(7'h7F)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                instr_valid,
  input  logic                stall,
  input  logic                flush,
  input  logic                resume,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                Branch,
  output logic [1:0]          ALUOp,
  output logic                Jump,
  output logic                ctrl_valid,
  output logic                illegal_op,
  output logic                fetch_en,
  output logic                halted
);

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_I    = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(7'b1100011);
`ifdef CTRL_JUMP_EN
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OP_JALR = OPCODE_W'(7'b1100111);
`endif

  // Counter is loaded with DRAIN_CYCLES-1 so HALTED is reached DRAIN_CYCLES edges after HLT.
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
  } ctrl_t;

  typedef struct packed {
    logic  legal;
    ctrl_t ctrl;
  } dec_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Opcode to control-bundle table; anything not listed (HLT included) is illegal.
  function automatic dec_t decode_op(input logic [OPCODE_W-1:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_R: begin
        d.legal          = 1'b1;
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_op    = 2'b10;
      end
      OP_I: begin
        d.legal          = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_op    = 2'b11;
      end
      OP_LW: begin
        d.legal           = 1'b1;
        d.ctrl.alu_src    = 1'b1;
        d.ctrl.mem_to_reg = 1'b1;
        d.ctrl.reg_write  = 1'b1;
        d.ctrl.mem_read   = 1'b1;
        d.ctrl.alu_op     = 2'b00;
      end
      OP_SW: begin
        d.legal          = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.mem_write = 1'b1;
        d.ctrl.alu_op    = 2'b00;
      end
      OP_BR: begin
        d.legal       = 1'b1;
        d.ctrl.branch = 1'b1;
        d.ctrl.alu_op = 2'b01;
      end
`ifdef CTRL_JUMP_EN
      OP_JAL: begin
        d.legal          = 1'b1;
        d.ctrl.reg_write = 1'b1;
        d.ctrl.jump      = 1'b1;
        d.ctrl.alu_op    = 2'b00;
      end
      OP_JALR: begin
        d.legal          = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.reg_write = 1'b1;
        d.ctrl.jump      = 1'b1;
        d.ctrl.alu_op    = 2'b00;
      end
`endif
      default: begin
        d = '0;
      end
    endcase
    return d;
  endfunction

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       fetch_en_q;
  logic       halted_q;

  ctrl_t      ctrl_q;
  ctrl_t      ctrl_d;
  logic       ctrl_valid_q;
  logic       ctrl_valid_d;
  logic       illegal_q;
  logic       illegal_d;

  dec_t       dec_s;
  logic       run_s;
  logic       accept_s;
  logic       hlt_go_s;

  // Next ID/EX bundle: flush beats stall beats load; only RUN loads real instructions.
  always_comb begin
    dec_s    = decode_op(Opcode);
    run_s    = (state_q == ST_RUN);
    accept_s = run_s & instr_valid & ~stall & ~flush;
    hlt_go_s = accept_s & (Opcode == HLT_OPCODE);
    ctrl_d       = '0;
    ctrl_valid_d = 1'b0;
    if (flush) begin
      ctrl_d       = '0;
      ctrl_valid_d = 1'b0;
    end else if (stall) begin
      ctrl_d       = ctrl_q;
      ctrl_valid_d = ctrl_valid_q;
    end else if (run_s && instr_valid && dec_s.legal) begin
      ctrl_d       = dec_s.ctrl;
      ctrl_valid_d = 1'b1;
    end else begin
      ctrl_d       = '0;
      ctrl_valid_d = 1'b0;
    end
    // HLT is undecodable on purpose but is a request, not an error.
    illegal_d = accept_s & ~dec_s.legal & (Opcode != HLT_OPCODE);
  end

  // ID/EX control register and the illegal-opcode pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q       <= '0;
      ctrl_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      ctrl_valid_q <= ctrl_valid_d;
      illegal_q    <= illegal_d;
    end
  end

  // Halt sequencer: RUN -> DRAIN on accepted HLT, DRAIN counts down to HALTED, resume returns to RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      cnt_q      <= 4'd0;
      fetch_en_q <= 1'b1;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hlt_go_s) begin
            state_q    <= ST_DRAIN;
            cnt_q      <= DRAIN_INIT;
            fetch_en_q <= 1'b0;
          end else begin
            fetch_en_q <= 1'b1;
          end
          halted_q <= 1'b0;
        end
        ST_DRAIN: begin
          fetch_en_q <= 1'b0;
          if (cnt_q == 4'd0) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end else begin
            cnt_q    <= cnt_q - 4'd1;
            halted_q <= 1'b0;
          end
        end
        ST_HALTED: begin
          if (resume) begin
            state_q    <= ST_RUN;
            halted_q   <= 1'b0;
            fetch_en_q <= 1'b1;
          end else begin
            halted_q   <= 1'b1;
            fetch_en_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_RUN;
          cnt_q      <= 4'd0;
          fetch_en_q <= 1'b1;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ALUSrc     = ctrl_q.alu_src;
  assign MemtoReg   = ctrl_q.mem_to_reg;
  assign RegWrite   = ctrl_q.reg_write;
  assign MemRead    = ctrl_q.mem_read;
  assign MemWrite   = ctrl_q.mem_write;
  assign Branch     = ctrl_q.branch;
  assign ALUOp      = ctrl_q.alu_op;
  assign Jump       = ctrl_q.jump;
  assign ctrl_valid = ctrl_valid_q;
  assign illegal_op = illegal_q;
  assign fetch_en   = fetch_en_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_pipelined_controller.sv
// Testbench for pipelined_controller: directed steps followed by randomized
// traffic, each edge checked against a behavioural model of the ID/EX bundle
// and the halt sequence.
module tb_pipelined_controller;

  localparam int DRAIN = 3;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HLT  = 7'h7F;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] Opcode;
  logic       instr_valid, stall, flush, resume;
  logic       ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump;
  logic [1:0] ALUOp;
  logic       ctrl_valid, illegal_op, fetch_en, halted;
  logic [8:0] dut_b;

  always #5 clk = ~clk;

  pipelined_controller #(.OPCODE_W(7), .DRAIN_CYCLES(DRAIN), .HLT_OPCODE(OP_HLT)) dut (
    .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .instr_valid(instr_valid),
    .stall(stall), .flush(flush), .resume(resume),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp), .Jump(Jump),
    .ctrl_valid(ctrl_valid), .illegal_op(illegal_op), .fetch_en(fetch_en), .halted(halted)
  );

  assign dut_b = {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Jump};

  int checks = 0;
  int errors = 0;

  // Reference model: pipeline mode 0=running 1=draining 2=halted; edges_left = edges until halted.
  logic [8:0] m_bundle;
  logic       m_valid, m_ill, m_fetch, m_halted;
  int         m_mode, m_edges_left;

  // {legal, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0], Jump}
  function automatic logic [9:0] ref_dec(input logic [6:0] op);
    case (op)
      OP_R:    return 10'b1_001000_10_0;
      OP_I:    return 10'b1_101000_11_0;
      OP_LW:   return 10'b1_111100_00_0;
      OP_SW:   return 10'b1_100010_00_0;
      OP_BR:   return 10'b1_000001_01_0;
`ifdef CTRL_JUMP_EN
      OP_JAL:  return 10'b1_001000_00_1;
      OP_JALR: return 10'b1_101000_00_1;
`endif
      default: return 10'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/bundle"},     16'(dut_b),      16'(m_bundle));
    check({tag, "/ctrl_valid"}, 16'(ctrl_valid), 16'(m_valid));
    check({tag, "/illegal_op"}, 16'(illegal_op), 16'(m_ill));
    check({tag, "/fetch_en"},   16'(fetch_en),   16'(m_fetch));
    check({tag, "/halted"},     16'(halted),     16'(m_halted));
  endtask

  task automatic model_reset();
    m_bundle = '0; m_valid = 1'b0; m_ill = 1'b0; m_fetch = 1'b1; m_halted = 1'b0;
    m_mode = 0; m_edges_left = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic [9:0] d;
    logic       running, accepted;
    d        = ref_dec(Opcode);
    running  = (m_mode == 0);
    accepted = running && instr_valid && !stall && !flush;
    if (flush) begin
      m_bundle = '0; m_valid = 1'b0;
    end else if (!stall) begin
      m_bundle = (running && instr_valid) ? d[8:0] : 9'd0;
      m_valid  = running && instr_valid && d[9];
    end
    m_ill = accepted && !d[9] && (Opcode != OP_HLT);
    if (accepted && Opcode == OP_HLT) begin
      m_mode = 1; m_edges_left = DRAIN; m_fetch = 1'b0;
    end else if (m_mode == 1) begin
      m_edges_left--;
      if (m_edges_left == 0) begin
        m_mode = 2; m_halted = 1'b1;
      end
    end else if (m_mode == 2 && resume) begin
      m_mode = 0; m_halted = 1'b0; m_fetch = 1'b1;
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic iv, input logic st,
                       input logic fl, input logic rs);
    Opcode = op; instr_valid = iv; stall = st; flush = fl; resume = rs;
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Mid-cycle asynchronous reset: outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic [6:0] pool [10];

  initial begin
    int n;
    pool = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, 7'h00, OP_HLT, 7'h2B};
    reset_n = 1'b1;
    drive(7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Decode table, one instruction per edge.
    drive(OP_R, 1'b1, 1'b0, 1'b0, 1'b0);  tick("dec_r");
    drive(OP_I, 1'b1, 1'b0, 1'b0, 1'b0);  tick("dec_i");
    drive(OP_LW, 1'b1, 1'b0, 1'b0, 1'b0); tick("dec_lw");
    check("lw_fields", 16'({ALUSrc, MemtoReg, RegWrite, MemRead, ALUOp, ctrl_valid}), 16'b1111001);
    drive(OP_SW, 1'b1, 1'b0, 1'b0, 1'b0); tick("dec_sw");
    drive(OP_BR, 1'b1, 1'b0, 1'b0, 1'b0); tick("dec_br");
    drive(OP_BR, 1'b0, 1'b0, 1'b0, 1'b0); tick("bubble");

    // Async reset with a loaded bundle.
    drive(OP_LW, 1'b1, 1'b0, 1'b0, 1'b0); tick("pre_rst");
    async_reset("rst_mid");

    // Stall holds LW, stall+flush clears.
    drive(OP_LW, 1'b1, 1'b0, 1'b0, 1'b0); tick("st_lw");
    drive(OP_SW, 1'b1, 1'b1, 1'b0, 1'b0); tick("stall1");
    tick("stall2");
    check("stall_hold", 16'(dut_b), 16'(9'b111100000));
    drive(OP_SW, 1'b1, 1'b1, 1'b1, 1'b0); tick("stall_flush");
    check("flush_zero", 16'({dut_b, ctrl_valid}), 16'd0);

    // Jump opcodes and an undecodable opcode.
    drive(OP_JAL, 1'b1, 1'b0, 1'b0, 1'b0); tick("jal");
`ifdef CTRL_JUMP_EN
    check("jal_on", 16'({Jump, RegWrite, ctrl_valid, illegal_op}), 16'b1110);
`else
    check("jal_off", 16'({dut_b, ctrl_valid, illegal_op}), 16'b1);
`endif
    drive(OP_JALR, 1'b1, 1'b0, 1'b0, 1'b0); tick("jalr");
    drive(7'h00, 1'b1, 1'b0, 1'b0, 1'b0); tick("op_zero");
    check("ill_pulse", 16'(illegal_op), 16'd1);
    drive(OP_R, 1'b1, 1'b0, 1'b0, 1'b0);  tick("ill_end");
    check("ill_drop", 16'(illegal_op), 16'd0);

    // HLT: stall delays, flush cancels, then drain/halt/resume.
    drive(OP_HLT, 1'b1, 1'b1, 1'b0, 1'b0); tick("hlt_stall");
    drive(OP_HLT, 1'b1, 1'b0, 1'b1, 1'b0); tick("hlt_flush");
    check("hlt_flush_run", 16'(fetch_en), 16'd1);
    drive(OP_HLT, 1'b1, 1'b0, 1'b0, 1'b1); tick("hlt");
    check("hlt_fetch_off", 16'(fetch_en), 16'd0);
    drive(OP_R, 1'b1, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!halted && n < 20) begin
      tick("drain");
      n++;
    end
    check("drain_edges", 16'(n), 16'(DRAIN));
    drive(OP_R, 1'b1, 1'b0, 1'b0, 1'b0); tick("halt_hold");
    check("halted_hold", 16'({halted, fetch_en, ctrl_valid}), 16'b100);
    drive(OP_R, 1'b1, 1'b0, 1'b0, 1'b1); tick("resume");
    check("resumed", 16'({halted, fetch_en}), 16'b01);

    // Reset in the middle of the drain (counter at 1).
    drive(OP_HLT, 1'b1, 1'b0, 1'b0, 1'b0); tick("hlt2");
    drive(OP_R, 1'b1, 1'b0, 1'b0, 1'b0);   tick("drain2");
    async_reset("rst_drain");
    tick("post_rst");
    check("post_rst_run", 16'({fetch_en, halted}), 16'b10);
    tick("post_rst2");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(pool[$urandom_range(0, 9)], 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 2) == 0));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
